// File: rtl/key_input_conditioner.sv
//------------------------------------------------------------------------------
// key_input_conditioner
//
// Cleans up the raw DIP switches and push-buttons that drive the LED PWM
// breathing stage. Every channel is passed through a two-flop synchronizer
// and a counter-based debouncer. The block produces clean levels and
// single-cycle rise/fall pulses. Two of the channels step a saturating 3-bit
// speed-select register.
//
// Parameters:
//   CH         number of input channels
//   DB_CYCLES  stable cycles at the synchronizer output before a level change
//              is accepted (must be >= 2)
//   CNT_W      debounce counter width (2**CNT_W >= DB_CYCLES)
//   EN_CH      channel forwarded to pwm_en
//   UP_CH      channel whose rising edge increments speed
//   DN_CH      channel whose rising edge decrements speed
//   SPEED_RST  reset value of speed
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst     in   1   synchronous reset, active low
//   raw_in  in   CH  asynchronous switch/button inputs, active high
//   level   out  CH  debounced level per channel
//   rise    out  CH  one-cycle pulse when level goes 0->1
//   fall    out  CH  one-cycle pulse when level goes 1->0
//   pwm_en  out  1   level[EN_CH]
//   speed   out  3   saturating speed select, 0..7
//------------------------------------------------------------------------------
module key_input_conditioner #(
   parameter int CH        = 4,
   parameter int DB_CYCLES = 1000000,
   parameter int CNT_W     = 20,
   parameter int EN_CH     = 0,
   parameter int UP_CH     = 1,
   parameter int DN_CH     = 2,
   parameter int SPEED_RST = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] raw_in,
   output logic [CH-1:0] level,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic          pwm_en,
   output logic [2:0]    speed
);

   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [2:0]       SPEED_INIT = 3'(SPEED_RST);

   //---------------------------------------------------------------------------
   // Per-channel synchronizer and debouncer
   //---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         logic             s1_reg;
         logic             s2_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             level_reg;
         logic             level_next;
         logic             rise_reg;
         logic             rise_next;
         logic             fall_reg;
         logic             fall_next;

         // The counter measures how long s2 has disagreed with the accepted
         // level. Any agreement clears it, so a glitch must not only end
         // but also leaves no partial credit behind for the next one.
         always_comb begin
            cnt_next   = '0;
            level_next = level_reg;
            rise_next  = 1'b0;
            fall_next  = 1'b0;
            if (s2_reg != level_reg) begin
               if (cnt_reg >= CNT_MAX) begin
                  // The mismatch has lasted the full debounce period. Accept
                  // it, and flag the direction of the change.
                  level_next = s2_reg;
                  rise_next  = s2_reg;
                  fall_next  = ~s2_reg;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               s1_reg    <= 1'b0;
               s2_reg    <= 1'b0;
               cnt_reg   <= '0;
               level_reg <= 1'b0;
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
            end else begin
               s1_reg    <= raw_in[gi];
               s2_reg    <= s1_reg;
               cnt_reg   <= cnt_next;
               level_reg <= level_next;
               rise_reg  <= rise_next;
               fall_reg  <= fall_next;
            end
         end

         assign level[gi] = level_reg;
         assign rise[gi]  = rise_reg;
         assign fall[gi]  = fall_reg;
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Speed select. It is driven from the registered rise pulses, so it moves
   // one edge after the pulse becomes visible. Up and down on the same cycle
   // cancel each other out.
   //---------------------------------------------------------------------------
   logic [2:0] speed_reg;
   logic [2:0] speed_next;
   logic       step_up;
   logic       step_dn;

   assign step_up = rise[UP_CH];
   assign step_dn = rise[DN_CH];

   always_comb begin
      speed_next = speed_reg;
      case ({step_up, step_dn})
         2'b10:   if (speed_reg != 3'd7) speed_next = speed_reg + 3'd1;
         2'b01:   if (speed_reg != 3'd0) speed_next = speed_reg - 3'd1;
         default: speed_next = speed_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         speed_reg <= SPEED_INIT;
      end else begin
         speed_reg <= speed_next;
      end
   end

   assign speed  = speed_reg;
   assign pwm_en = level[EN_CH];

endmodule

// File: tb/tb_key_input_conditioner.sv
//------------------------------------------------------------------------------
// Testbench for key_input_conditioner (DB_CYCLES=4, CNT_W=3).
// A behavioural model keeps a sliding window of the last DB synchronized
// samples per channel. The level flips when the whole window disagrees with
// it. Every cycle, the DUT outputs are compared against the model. Directed
// scenarios also check fixed expected values.
//------------------------------------------------------------------------------
module tb_key_input_conditioner;

   localparam int CH = 4;
   localparam int DB = 4;
   localparam int UP = 1;
   localparam int DN = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] raw_in;
   logic [CH-1:0] level;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic          pwm_en;
   logic [2:0]    speed;

   always #5 clk = ~clk;

   key_input_conditioner #(
      .CH(CH), .DB_CYCLES(DB), .CNT_W(3),
      .EN_CH(0), .UP_CH(UP), .DN_CH(DN), .SPEED_RST(3)
   ) dut (
      .clk(clk), .rst(rst), .raw_in(raw_in),
      .level(level), .rise(rise), .fall(fall),
      .pwm_en(pwm_en), .speed(speed)
   );

   // Reference model state
   logic [CH-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
   int            m_speed;
   bit            hist [CH][DB];
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge, using the inputs seen at that edge.
   task automatic model_step();
      int mism;
      if (!rst) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
         m_speed = 3;
         for (int c = 0; c < CH; c++)
            for (int k = 0; k < DB; k++) hist[c][k] = 1'b0;
      end else begin
         if (m_rise[UP] && !m_rise[DN])      m_speed = (m_speed < 7) ? m_speed + 1 : 7;
         else if (m_rise[DN] && !m_rise[UP]) m_speed = (m_speed > 0) ? m_speed - 1 : 0;
         for (int c = 0; c < CH; c++) begin
            for (int k = DB - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = m_s2[c];
            mism = 0;
            for (int k = 0; k < DB; k++) if (hist[c][k] != m_level[c]) mism++;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (mism == DB) begin
               m_level[c] = ~m_level[c];
               m_rise[c]  = m_level[c];
               m_fall[c]  = ~m_level[c];
               $display("t=%0t ch%0d level -> %0b", $time, c, m_level[c]);
            end
         end
         m_s2 = m_s1;
         m_s1 = raw_in;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("level",  level,  m_level);
      check("rise",   rise,   m_rise);
      check("fall",   fall,   m_fall);
      check("pwm_en", pwm_en, m_level[0]);
      check("speed",  speed,  m_speed);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press(input int ch);
      raw_in[ch] = 1'b1;
      run(8);
      raw_in[ch] = 1'b0;
      run(8);
   endtask

   int sat_up [5] = '{4, 5, 6, 7, 7};
   int sat_dn [9] = '{6, 5, 4, 3, 2, 1, 0, 0, 0};

   initial begin
      // Reset with every input held high
      rst = 1'b0; raw_in = 4'b1111;
      run(3);
      check("rst_level", level, 0);
      check("rst_rise",  rise, 0);
      check("rst_fall",  fall, 0);
      check("rst_speed", speed, 3);
      check("rst_pwm",   pwm_en, 0);
      rst = 1'b1;
      run(5);
      check("post_rst_level_E4", level, 4'b0000);
      run(1);
      check("post_rst_level_E5", level, 4'b1111);
      check("post_rst_rise_E5",  rise, 4'b1111);
      run(1);
      check("post_rst_rise_E6",  rise, 4'b0000);
      raw_in = 4'b0000;
      run(10);
      check("both_rise_hold", speed, 3);

      // Clean press on ch0
      raw_in = 4'b0001;
      run(5);
      check("press_pwm_E4", pwm_en, 0);
      run(1);
      check("press_pwm_E5", pwm_en, 1);
      check("press_rise_E5", rise, 4'b0001);
      run(1);
      check("press_rise_E6", rise, 4'b0000);
      run(5);
      raw_in = 4'b0000;
      run(5);
      run(1);
      check("release_fall_E5", fall, 4'b0001);
      run(6);
      check("press_speed", speed, 3);

      // Glitch: 3 cycles rejected, 4 cycles accepted
      raw_in = 4'b0010; run(3);
      raw_in = 4'b0000; run(10);
      check("glitch3_level", level, 4'b0000);
      check("glitch3_speed", speed, 3);
      raw_in = 4'b0010; run(4);
      raw_in = 4'b0000; run(10);
      check("glitch4_speed", speed, 4);

      // Saturation from reset value
      rst = 1'b0; run(2); rst = 1'b1; run(2);
      for (int i = 0; i < 5; i++) begin
         press(UP);
         check("sat_up", speed, sat_up[i]);
      end
      for (int i = 0; i < 9; i++) begin
         press(DN);
         check("sat_dn", speed, sat_dn[i]);
      end

      // Simultaneous up and down
      press(UP);
      check("pre_sim_speed", speed, 1);
      raw_in = 4'b0110; run(8);
      check("sim_speed", speed, 1);
      raw_in = 4'b0000; run(8);

      // Reset in the middle of a count
      raw_in = 4'b0001;
      run(3);
      rst = 1'b0; run(1);
      rst = 1'b1; run(5);
      check("midrst_level_E8", level[0], 0);
      check("midrst_rise_E8",  rise[0], 0);
      run(1);
      check("midrst_level_E9", level[0], 1);
      check("midrst_rise_E9",  rise[0], 1);
      run(4);
      raw_in = 4'b0000; run(10);

      // Random stimulus against the model
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 299) != 0);
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 3) == 0) raw_in[c] = ~raw_in[c];
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
